// File: rtl/psum_accum_sfu_pkg.sv
// Shared types, sizes and the saturate/ReLU helper for the psum accumulator / SFU stage.
package psum_accum_sfu_pkg;

  localparam int COL      = 8;
  localparam int PSUM_BW  = 16;
  localparam int ACC_BW   = 20;
  localparam int NUM_OUT  = 16;
  localparam int NUM_PASS = 9;
  localparam int ADDR_BW  = 4;
  localparam int PASS_BW  = 4;

  localparam logic signed [ACC_BW-1:0] SAT_MAX = ACC_BW'((1 << (PSUM_BW - 1)) - 1);
  localparam logic signed [ACC_BW-1:0] SAT_MIN = -SAT_MAX - ACC_BW'(1);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    WRITE,
    DONE
  } state_t;

  // Clamp to the signed output range first, then zero anything negative.
  function automatic logic [PSUM_BW-1:0] sat_relu(input logic signed [ACC_BW-1:0] acc);
    logic signed [ACC_BW-1:0] sat;
    if (acc > SAT_MAX) begin
      sat = SAT_MAX;
    end else if (acc < SAT_MIN) begin
      sat = SAT_MIN;
    end else begin
      sat = acc;
    end
    return sat[ACC_BW-1] ? '0 : sat[PSUM_BW-1:0];
  endfunction

endpackage

// File: rtl/psum_accum_sfu_lane.sv
// One lane of the accumulator datapath: sign-extended accumulate and the writeback sat/ReLU.
module sfu_lane
  import psum_accum_sfu_pkg::*;
(
  input  logic [PSUM_BW-1:0] i_psum,
  input  logic               i_first,
  input  logic [ACC_BW-1:0]  i_acc,
  output logic [ACC_BW-1:0]  o_accNext,
  input  logic [ACC_BW-1:0]  i_wbAcc,
  output logic [PSUM_BW-1:0] o_wbData
);

  logic [ACC_BW-1:0] w_psumExt;

  assign w_psumExt = {{(ACC_BW - PSUM_BW){i_psum[PSUM_BW-1]}}, i_psum};

  // The first pass overwrites, so stale results from a previous sequence never leak in.
  assign o_accNext = i_first ? w_psumExt : i_acc + w_psumExt;
  assign o_wbData  = sat_relu(i_wbAcc);

endmodule

// File: rtl/psum_accum_sfu.sv
// Accumulates NUM_PASS passes of NUM_OUT psum vectors, then writes sat/ReLU results to OP_SRAM.
module psum_accum_sfu
  import psum_accum_sfu_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     seq_begin,
  input  logic                     psum_valid,
  output logic                     psum_ready,
  input  logic [COL*PSUM_BW-1:0]   psum_data,
  output logic                     op_cen,
  output logic                     op_wen,
  output logic [ADDR_BW-1:0]       op_addr,
  output logic [COL*PSUM_BW-1:0]   op_d,
  output logic                     busy,
  output logic                     sfu_done
);

  localparam logic [ADDR_BW-1:0] LAST_VEC  = ADDR_BW'(NUM_OUT - 1);
  localparam logic [PASS_BW-1:0] LAST_PASS = PASS_BW'(NUM_PASS - 1);

  state_t r_state;
  state_t w_nextState;

  logic [ADDR_BW-1:0]     r_vecCnt;
  logic [PASS_BW-1:0]     r_passCnt;
  logic [ACC_BW-1:0]      r_acc [NUM_OUT][COL];

  logic                   r_psumReady;
  logic                   r_opCen;
  logic                   r_opWen;
  logic [ADDR_BW-1:0]     r_opAddr;
  logic [COL*PSUM_BW-1:0] r_opD;
  logic                   r_busy;
  logic                   r_sfuDone;

  logic                   w_handshake;
  logic                   w_lastVec;
  logic                   w_lastPass;
  logic                   w_first;
  logic [ADDR_BW-1:0]     w_wrAddr;
  logic [ACC_BW-1:0]      w_accNext [COL];
  logic [PSUM_BW-1:0]     w_wbData [COL];
  logic [COL*PSUM_BW-1:0] w_wbPacked;

  assign w_handshake = psum_valid & r_psumReady;
  assign w_lastVec   = (r_vecCnt == LAST_VEC);
  assign w_lastPass  = (r_passCnt == LAST_PASS);
  assign w_first     = (r_passCnt == '0);

  // The address being loaded into the output register: 0 on WRITE entry, then sequential.
  assign w_wrAddr = (r_state == WRITE) ? r_opAddr + 1'b1 : '0;

  for (genvar g = 0; g < COL; g++) begin : g_lane
    sfu_lane u_lane (
      .i_psum    (psum_data[g*PSUM_BW +: PSUM_BW]),
      .i_first   (w_first),
      .i_acc     (r_acc[r_vecCnt][g]),
      .o_accNext (w_accNext[g]),
      .i_wbAcc   (r_acc[w_wrAddr][g]),
      .o_wbData  (w_wbData[g])
    );
  end

  always_comb begin
    w_wbPacked = '0;
    for (int c = 0; c < COL; c++) begin
      w_wbPacked[c*PSUM_BW +: PSUM_BW] = w_wbData[c];
    end
  end

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE:  if (seq_begin) w_nextState = ACCUM;
      ACCUM: if (w_handshake && w_lastVec && w_lastPass) w_nextState = WRITE;
      WRITE: if (r_opAddr == LAST_VEC) w_nextState = DONE;
      DONE:  w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vecCnt  <= '0;
      r_passCnt <= '0;
    end else if (r_state == DONE) begin
      r_vecCnt  <= '0;
      r_passCnt <= '0;
    end else if (w_handshake) begin
      if (w_lastVec) begin
        r_vecCnt  <= '0;
        r_passCnt <= r_passCnt + 1'b1;
      end else begin
        r_vecCnt  <= r_vecCnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int v = 0; v < NUM_OUT; v++) begin
        for (int c = 0; c < COL; c++) begin
          r_acc[v][c] <= '0;
        end
      end
    end else if (w_handshake) begin
      for (int c = 0; c < COL; c++) begin
        r_acc[r_vecCnt][c] <= w_accNext[c];
      end
    end
  end

  // Outputs are decoded from the next state so each one lines up with its state cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_psumReady <= 1'b0;
      r_opCen     <= 1'b1;
      r_opWen     <= 1'b1;
      r_opAddr    <= '0;
      r_opD       <= '0;
      r_busy      <= 1'b0;
      r_sfuDone   <= 1'b0;
    end else begin
      r_psumReady <= (w_nextState == ACCUM);
      r_opCen     <= (w_nextState != WRITE);
      r_opWen     <= (w_nextState != WRITE);
      r_opAddr    <= (w_nextState == WRITE) ? w_wrAddr : '0;
      r_opD       <= (w_nextState == WRITE) ? w_wbPacked : '0;
      r_busy      <= (w_nextState != IDLE);
      r_sfuDone   <= (w_nextState == DONE);
    end
  end

  assign psum_ready = r_psumReady;
  assign op_cen     = r_opCen;
  assign op_wen     = r_opWen;
  assign op_addr    = r_opAddr;
  assign op_d       = r_opD;
  assign busy       = r_busy;
  assign sfu_done   = r_sfuDone;

endmodule

// File: tb/tb_psum_accum_sfu.sv
// Directed bench for psum_accum_sfu: reset, accumulate, sat/ReLU, backpressure and sequencing.
module tb_psum_accum_sfu;

  localparam int LANES  = 8;
  localparam int VECS   = 16;
  localparam int PASSES = 9;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         seq_begin = 1'b0;
  logic         psum_valid = 1'b0;
  logic         psum_ready;
  logic [127:0] psum_data = '0;
  logic         op_cen;
  logic         op_wen;
  logic [3:0]   op_addr;
  logic [127:0] op_d;
  logic         busy;
  logic         sfu_done;

  int vectors = 0;
  int miscompares = 0;
  int writeCount = 0;
  int hsCount = 0;
  int doneCount = 0;
  logic [127:0] captured [VECS];

  always #5 clk = ~clk;

  psum_accum_sfu dut (
    .clk        (clk),
    .reset      (reset),
    .seq_begin  (seq_begin),
    .psum_valid (psum_valid),
    .psum_ready (psum_ready),
    .psum_data  (psum_data),
    .op_cen     (op_cen),
    .op_wen     (op_wen),
    .op_addr    (op_addr),
    .op_d       (op_d),
    .busy       (busy),
    .sfu_done   (sfu_done)
  );

  // Mid-cycle observer: SRAM writes, done pulses and accepted handshakes.
  always @(negedge clk) begin
    if (!op_cen && !op_wen) begin
      captured[op_addr] = op_d;
      writeCount++;
    end
    if (sfu_done) doneCount++;
    if (psum_valid && psum_ready) hsCount++;
  end

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] vecData(input int test, input int pass, input int vec);
    logic [127:0] d;
    int val;
    d = '0;
    for (int lane = 0; lane < LANES; lane++) begin
      case (test)
        3: begin
          if (vec == 0)      val = -5;
          else if (vec == 1) val = 4000;
          else if (vec == 2) val = (lane % 2 == 0) ? 3 : -1;
          else               val = lane + vec;
        end
        6:       val = (vec + 1) * (lane + 1) - 40 + pass;
        default: val = 1;
      endcase
      d[lane*16 +: 16] = 16'(val);
    end
    return d;
  endfunction

  function automatic logic [127:0] expectVec(input int test, input int vec);
    logic [127:0] r;
    logic [127:0] d;
    logic signed [15:0] lv;
    int sum;
    if (test == 2) return {8{16'd9}};
    if (test == 3 && vec == 0) return '0;
    if (test == 3 && vec == 1) return {8{16'h7FFF}};
    if (test == 3 && vec == 2) return {4{16'd0, 16'd27}};
    r = '0;
    for (int lane = 0; lane < LANES; lane++) begin
      sum = 0;
      for (int p = 0; p < PASSES; p++) begin
        d = vecData(test, p, vec);
        lv = d[lane*16 +: 16];
        sum += int'(lv);
      end
      if (sum < 0) sum = 0;
      if (sum > 32767) sum = 32767;
      r[lane*16 +: 16] = 16'(sum);
    end
    return r;
  endfunction

  task automatic applyStimulus(input logic [127:0] data, input bit gap);
    int waitCycles;
    if (gap && $urandom_range(0, 1) == 1) begin
      psum_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    psum_valid = 1'b1;
    psum_data  = data;
    waitCycles = 0;
    forever begin
      @(negedge clk);
      if (psum_ready) break;
      waitCycles++;
      if (waitCycles > 50) begin
        checkOutput("ready_timeout", 128'(psum_ready), 128'(1));
        psum_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    psum_valid = 1'b0;
  endtask

  task automatic runSequence(input int test, input bit gaps, input bit poke, input string name);
    int n;
    int doneBefore;
    writeCount = 0;
    hsCount    = 0;
    doneBefore = doneCount;
    @(posedge clk); #1 seq_begin = 1'b1;
    @(posedge clk); #1 seq_begin = 1'b0;
    checkOutput({name, "_busy_start"}, 128'(busy), 128'(1));
    for (int p = 0; p < PASSES; p++) begin
      for (int v = 0; v < VECS; v++) begin
        if (poke && p == 3 && v == 2) seq_begin = 1'b1;
        applyStimulus(vecData(test, p, v), gaps);
        seq_begin = 1'b0;
      end
    end
    checkOutput({name, "_handshakes"}, 128'(hsCount), 128'(144));
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        checkOutput({name, "_ready_drop"}, 128'(psum_ready), 128'(0));
        checkOutput({name, "_first_cen"}, 128'(op_cen), 128'(0));
        checkOutput({name, "_first_addr"}, 128'(op_addr), 128'(0));
      end
      if (poke && n == 6) seq_begin = 1'b1;
      if (poke && n == 7) seq_begin = 1'b0;
      if (sfu_done) break;
    end
    checkOutput({name, "_done_latency"}, 128'(n), 128'(17));
    @(negedge clk);
    checkOutput({name, "_done_pulse_width"}, 128'(sfu_done), 128'(0));
    checkOutput({name, "_idle_busy"}, 128'(busy), 128'(0));
    repeat (3) @(negedge clk);
    checkOutput({name, "_done_count"}, 128'(doneCount - doneBefore), 128'(1));
    checkOutput({name, "_still_idle"}, 128'(busy), 128'(0));
    checkOutput({name, "_write_count"}, 128'(writeCount), 128'(16));
    for (int k = 0; k < VECS; k++) begin
      checkOutput($sformatf("%s_addr%0d", name, k), captured[k], expectVec(test, k));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    $display("[TB] starting psum_accum_sfu bench");
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_psum_ready", 128'(psum_ready), 128'(0));
    checkOutput("rst_op_cen", 128'(op_cen), 128'(1));
    checkOutput("rst_op_wen", 128'(op_wen), 128'(1));
    checkOutput("rst_op_addr", 128'(op_addr), 128'(0));
    checkOutput("rst_op_d", op_d, 128'(0));
    checkOutput("rst_busy", 128'(busy), 128'(0));
    checkOutput("rst_sfu_done", 128'(sfu_done), 128'(0));
    reset = 1'b1;

    $display("[TB] reset during accumulation");
    hsCount    = 0;
    writeCount = 0;
    @(posedge clk); #1 seq_begin = 1'b1;
    @(posedge clk); #1 seq_begin = 1'b0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecData(2, i / VECS, i % VECS), 1'b0);
    end
    checkOutput("midrst_handshakes", 128'(hsCount), 128'(20));
    #2 reset = 1'b0;
    #1;
    checkOutput("midrst_busy", 128'(busy), 128'(0));
    checkOutput("midrst_ready", 128'(psum_ready), 128'(0));
    checkOutput("midrst_cen", 128'(op_cen), 128'(1));
    @(posedge clk); #1 reset = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("midrst_no_writes", 128'(writeCount), 128'(0));
    @(posedge clk); #1;

    $display("[TB] basic accumulation after reset");
    runSequence(2, 1'b0, 1'b0, "basic");
    $display("[TB] relu and saturation");
    runSequence(3, 1'b0, 1'b0, "satrelu");
    $display("[TB] backpressure");
    runSequence(2, 1'b1, 1'b0, "bp");
    $display("[TB] seq_begin ignored while busy");
    runSequence(3, 1'b0, 1'b1, "ignore");
    $display("[TB] back-to-back with new data");
    runSequence(6, 1'b0, 1'b0, "b2b");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
